// File: rtl/dimc_row_sequencer.sv
// dimc_row_sequencer: loads features, issues credit-limited DIMC row computes and queues results in issue order.
module dimc_row_sequencer #(
    parameter int LAT = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ROWS = 32,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(ROWS + 1)
) (
    input  logic          RCK,
    input  logic          RESET,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [RW-1:0] cmd_row_start,
    input  logic [CW-1:0] cmd_row_count,
    input  logic [1:0]    cmd_mode,
    input  logic [7:0]    cmd_mct,
    input  logic [23:0]   cmd_bias,
    input  logic          feat_valid,
    output logic          feat_ready,
    input  logic [255:0]  feat_data,
    output logic          dimc_compe,
    output logic          dimc_rcsn,
    output logic [RW+1:0] dimc_ra,
    output logic          dimc_fcsn,
    output logic [1:0]    dimc_fa,
    output logic [255:0]  dimc_fd,
    output logic [1:0]    dimc_mode,
    output logic [7:0]    dimc_mct,
    output logic [23:0]   dimc_addin,
    input  logic          dimc_readyn,
    input  logic [23:0]   dimc_psout,
    input  logic [3:0]    dimc_res,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [23:0]   res_psum,
    output logic [3:0]    res_q,
    output logic [RW-1:0] res_row,
    output logic          res_last,
    output logic          busy,
    output logic          job_done,
    output logic          err_spurious
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(LAT + 1);
    localparam int EW = 24 + 4 + RW + 1;
    localparam logic [TW-1:0] TLAST = TW'(LAT);
    localparam logic [NW:0] DEPTH_N = (NW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;
    state_t state, nxt;

    logic [RW-1:0] start_r, issue_row;
    logic [CW-1:0] cnt_r, cnt_c, issue_n;
    logic [1:0]    beat;
    logic [NW-1:0] inflight, fifo_cnt;
    logic [NW:0]   occ;
    logic [FW-1:0] wp, rp;
    logic [TW-1:0] twp, trp;
    logic [RW:0]   tag_mem [LAT+1];
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic          accept, hs, issue, issue_last, cap, pop, zero_done;

    assign cmd_ready  = (state == IDLE) && !RESET;
    assign feat_ready = state == LOAD;
    assign busy       = state != IDLE;
    assign accept     = cmd_valid && cmd_ready;
    assign cnt_c      = (cmd_row_count > CW'(ROWS)) ? CW'(ROWS) : cmd_row_count;
    assign hs         = feat_valid && feat_ready;
    // Credit counts both queued results and rows whose result is still coming back.
    assign occ        = {1'b0, fifo_cnt} + {1'b0, inflight};
    assign issue      = (state == ISSUE) && (occ < DEPTH_N);
    assign issue_row  = start_r + issue_n[RW-1:0];
    assign issue_last = issue_n == cnt_r - CW'(1);
    assign cap        = !dimc_readyn && (inflight != '0);
    assign pop        = res_valid && res_ready;
    assign res_valid  = fifo_cnt != '0;
    assign {res_psum, res_q, res_row, res_last} = fifo_mem[rp];
    assign job_done   = zero_done || (state == DRAIN && inflight == '0);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (accept && cnt_c != '0) nxt = LOAD;
            LOAD:  if (hs && beat == 2'd3) nxt = ISSUE;
            ISSUE: if (issue && issue_last) nxt = DRAIN;
            DRAIN: if (inflight == '0) nxt = IDLE;
        endcase
    end

    always_ff @(posedge RCK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            start_r      <= '0;
            cnt_r        <= '0;
            issue_n      <= '0;
            beat         <= '0;
            inflight     <= '0;
            fifo_cnt     <= '0;
            wp           <= '0;
            rp           <= '0;
            twp          <= '0;
            trp          <= '0;
            zero_done    <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                start_r <= cmd_row_start;
                cnt_r   <= cnt_c;
            end
            issue_n      <= accept ? '0 : issue_n + CW'(issue);
            beat         <= beat + 2'(hs);
            zero_done    <= accept && cnt_c == '0;
            inflight     <= inflight + NW'(issue) - NW'(cap);
            fifo_cnt     <= fifo_cnt + NW'(cap) - NW'(pop);
            err_spurious <= err_spurious || (!dimc_readyn && inflight == '0);
            if (issue) twp <= (twp == TLAST) ? '0 : twp + 1'b1;
            if (cap) trp <= (trp == TLAST) ? '0 : trp + 1'b1;
            if (cap) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge RCK) begin
        if (issue) tag_mem[twp] <= {issue_row, issue_last};
        if (cap) fifo_mem[wp] <= {dimc_psout, dimc_res, tag_mem[trp]};
    end

    always_ff @(posedge RCK or posedge RESET) begin
        if (RESET) begin
            dimc_compe <= 1'b0;
            dimc_rcsn  <= 1'b1;
            dimc_ra    <= '0;
            dimc_fcsn  <= 1'b1;
            dimc_fa    <= '0;
            dimc_fd    <= '0;
            dimc_mode  <= '0;
            dimc_mct   <= '0;
            dimc_addin <= '0;
        end else begin
            dimc_compe <= issue;
            dimc_rcsn  <= !issue;
            dimc_fcsn  <= !hs;
            if (issue) dimc_ra <= {issue_row, 2'b00};
            if (hs) begin
                dimc_fa <= beat;
                dimc_fd <= feat_data;
            end
            if (accept && cnt_c != '0) begin
                dimc_mode  <= cmd_mode;
                dimc_mct   <= cmd_mct;
                dimc_addin <= cmd_bias;
            end else if (nxt == IDLE) begin
                dimc_mode  <= '0;
                dimc_mct   <= '0;
                dimc_addin <= '0;
            end
        end
    end
endmodule
